sound_i2s_tx: RTL

SOUND_I2S_TX -- requirements
Module: sound_i2s_tx

---
 rtl/sound_i2s_tx_if.sv | 26 ++
 rtl/sound_i2s_tx.sv | 75 +++++++
 2 files changed

// File: rtl/sound_i2s_tx_if.sv
// Bundles the mixer-side sample inputs and the I2S output pins of sound_i2s_tx.
// Latency: none (signal bundle only).
// Backpressure: none; the transmitter samples left/right only at its latch point.
// Signals: enable, left[15:0], right[15:0] (mixer -> tx); sample_strobe, i2s_bclk,
//          i2s_lrck, i2s_sdata (tx -> mixer/pins).
interface sound_i2s_tx_if;
    logic        enable;
    logic [15:0] left;
    logic [15:0] right;
    logic        sample_strobe;
    logic        i2s_bclk;
    logic        i2s_lrck;
    logic        i2s_sdata;

    // master: the sound mixer / board side that feeds samples and watches the pins
    modport master (
        output enable, left, right,
        input  sample_strobe, i2s_bclk, i2s_lrck, i2s_sdata
    );

    // slave: the transmitter itself
    modport slave (
        input  enable, left, right,
        output sample_strobe, i2s_bclk, i2s_lrck, i2s_sdata
    );
endinterface

// File: rtl/sound_i2s_tx.sv
// Stereo I2S transmitter: 16-bit left/right, 32 BCLK per frame, MSB first, 1-BCLK delay after lrck.
// Latency: first bclk fall 2*BCLK_DIV clks after enable; samples latched on the s=1 fall, 1 clk strobe.
// Backpressure: none; left/right are sampled only at the latch point, other changes are ignored.
// Ports: clk, rst (sync, active-high), bus (slave modport: enable, left, right in;
//        sample_strobe, i2s_bclk, i2s_lrck, i2s_sdata out, all registered).
module sound_i2s_tx #(
    parameter int unsigned BCLK_DIV = 2     // clk cycles per BCLK half-period, 1..255
) (
    input  logic          clk,
    input  logic          rst,
    sound_i2s_tx_if.slave bus
);
    localparam int unsigned SAMPLE_BITS = 16;
    localparam logic [7:0]  DIV_LAST    = 8'(BCLK_DIV - 1);

    logic [7:0]               div_cnt;
    logic [4:0]               slot;
    logic [2*SAMPLE_BITS-1:0] shreg;
    logic                     bclk;
    logic                     lrck;
    logic                     sdata;
    logic                     strobe;

    logic                     fall_evt;
    logic [4:0]               slot_nxt;

    // A fall event is the divider wrap while bclk is currently high.
    always_comb begin
        fall_evt = (div_cnt == DIV_LAST) && bclk;
        slot_nxt = slot + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst || !bus.enable) begin
            // Idle: slot parked at 31 so the first fall event lands on slot 0.
            div_cnt <= 8'd0;
            slot    <= 5'd31;
            shreg   <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
            sdata   <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            strobe <= 1'b0;

            if (div_cnt == DIV_LAST) begin
                div_cnt <= 8'd0;
                bclk    <= ~bclk;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end

            if (fall_evt) begin
                slot <= slot_nxt;
                lrck <= slot_nxt[4];
                if (slot_nxt == 5'd1) begin
                    // Latch point: left MSB goes straight out, the remaining 31 bits
                    // queue up in the shifter. The trailing zero is never sent because
                    // the shifter is reloaded on the next s=1.
                    sdata  <= bus.left[SAMPLE_BITS-1];
                    shreg  <= {bus.left[SAMPLE_BITS-2:0], bus.right, 1'b0};
                    strobe <= 1'b1;
                end else begin
                    sdata <= shreg[2*SAMPLE_BITS-1];
                    shreg <= {shreg[2*SAMPLE_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign bus.i2s_bclk      = bclk;
    assign bus.i2s_lrck      = lrck;
    assign bus.i2s_sdata     = sdata;
    assign bus.sample_strobe = strobe;
endmodule
